// File: rtl/digit_infer_pkg.sv
// digit_infer_pkg: FSM encoding, result word width and 32-bit saturation limits
// shared by the digit inference controller and its MAC datapath.
package digit_infer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MAC,
    DRAIN,
    STORE,
    ARGMAX,
    DONE
  } state_t;

  localparam int RES_W = 32;

  localparam longint SAT_MAX = 64'sd2147483647;
  localparam longint SAT_MIN = -64'sd2147483648;

  localparam logic [RES_W-1:0] RES_POS_LIMIT = 32'h7fff_ffff;
  localparam logic [RES_W-1:0] RES_NEG_LIMIT = 32'h8000_0000;

  // Clamp a sign-extended accumulator value into a signed RES_W-bit word.
  function automatic logic [RES_W-1:0] saturate(input longint value);
    logic [RES_W-1:0] word;
    if (value > SAT_MAX) begin
      word = RES_POS_LIMIT;
    end else if (value < SAT_MIN) begin
      word = RES_NEG_LIMIT;
    end else begin
      word = value[RES_W-1:0];
    end
    return word;
  endfunction

endpackage

// File: rtl/infer_mac.sv
// infer_mac: signed-weight x unsigned-pixel multiply-accumulate with 32-bit saturation.
// Define DIGIT_INFER_RELU_EN to clamp negative saturated scores to zero.
module infer_mac
  import digit_infer_pkg::*;
#(
  parameter int ACC_W = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic             dump,
  input  logic [7:0]       pix_data,
  input  logic [15:0]      w_data,
  output logic [RES_W-1:0] sat_word
);

  logic signed [ACC_W-1:0] acc_reg;
  logic signed [24:0]      w_ext;
  logic signed [24:0]      p_ext;
  logic signed [24:0]      product;
  logic [RES_W-1:0]        clipped;

  // 16x9 signed product always fits in 25 bits, so the truncated multiply is exact.
  assign w_ext   = {{9{w_data[15]}}, w_data};
  assign p_ext   = {17'b0, pix_data};
  assign product = w_ext * p_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= '0;
    end else if (clear || dump) begin
      acc_reg <= '0;
    end else if (enable) begin
      acc_reg <= acc_reg + {{(ACC_W-25){product[24]}}, product};
    end
  end

  assign clipped = saturate(64'(acc_reg));

`ifdef DIGIT_INFER_RELU_EN
  assign sat_word = clipped[RES_W-1] ? '0 : clipped;
`else
  assign sat_word = clipped;
`endif

endmodule

// File: rtl/digit_infer_ctrl.sv
// digit_infer_ctrl: sequences one fully-connected layer (N_IN pixels x N_OUT classes)
// over external memories, stores saturated scores and selects the arg-max class.
// Define DIGIT_INFER_RELU_EN to store negative scores as zero.
module digit_infer_ctrl
  import digit_infer_pkg::*;
#(
  parameter int N_IN  = 784,
  parameter int N_OUT = 10,
  parameter int ACC_W = 40,
  localparam int PIX_AW = (N_IN > 1) ? $clog2(N_IN) : 1,
  localparam int W_AW   = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [PIX_AW-1:0]      pix_addr,
  output logic [W_AW-1:0]        w_addr,
  input  logic [7:0]             pix_data,
  input  logic [15:0]            w_data,
  output logic [N_OUT*RES_W-1:0] res,
  output logic [3:0]             inference
);

  localparam int K_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  state_t                  state_reg;
  logic                    busy_reg;
  logic                    done_reg;
  logic                    mac_valid_reg;
  logic [PIX_AW-1:0]       pix_addr_reg;
  logic [W_AW-1:0]         w_addr_reg;
  logic [W_AW-1:0]         w_base_reg;
  logic [K_W-1:0]          k_reg;
  logic [K_W-1:0]          j_reg;
  logic signed [RES_W-1:0] max_reg;
  logic [3:0]              idx_reg;
  logic [3:0]              inference_reg;
  logic [RES_W-1:0]        res_reg [N_OUT];

  logic [RES_W-1:0]        sat_word;
  logic signed [RES_W-1:0] scan_word;
  logic                    scan_take;
  logic                    mac_clear;
  logic                    mac_dump;

  assign mac_clear = (state_reg == IDLE) && start;
  assign mac_dump  = (state_reg == STORE);

  // Strictly-greater replacement keeps the lowest index on ties.
  assign scan_word = res_reg[j_reg];
  assign scan_take = (j_reg == '0) || (scan_word > max_reg);

  infer_mac #(
    .ACC_W(ACC_W)
  ) u_mac (
    .clk      (clk_clk),
    .rst_n    (reset_reset_n),
    .clear    (mac_clear),
    .enable   (mac_valid_reg),
    .dump     (mac_dump),
    .pix_data (pix_data),
    .w_data   (w_data),
    .sat_word (sat_word)
  );

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_reg     <= IDLE;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      mac_valid_reg <= 1'b0;
      pix_addr_reg  <= '0;
      w_addr_reg    <= '0;
      w_base_reg    <= '0;
      k_reg         <= '0;
      j_reg         <= '0;
      max_reg       <= '0;
      idx_reg       <= '0;
      inference_reg <= '0;
      for (int n = 0; n < N_OUT; n++) begin
        res_reg[n] <= '0;
      end
    end else begin
      done_reg      <= 1'b0;
      // Memory data lags the address by one cycle, so accumulate the cycle after each MAC cycle.
      mac_valid_reg <= (state_reg == MAC);
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg    <= MAC;
            busy_reg     <= 1'b1;
            k_reg        <= '0;
            pix_addr_reg <= '0;
            w_addr_reg   <= '0;
            w_base_reg   <= W_AW'(N_IN);
          end
        end
        MAC: begin
          if (pix_addr_reg == PIX_AW'(N_IN - 1)) begin
            state_reg    <= DRAIN;
            pix_addr_reg <= '0;
            w_addr_reg   <= '0;
          end else begin
            pix_addr_reg <= pix_addr_reg + PIX_AW'(1);
            w_addr_reg   <= w_addr_reg + W_AW'(1);
          end
        end
        DRAIN: begin
          state_reg <= STORE;
        end
        STORE: begin
          res_reg[k_reg] <= sat_word;
          if (k_reg == K_W'(N_OUT - 1)) begin
            state_reg <= ARGMAX;
            j_reg     <= '0;
          end else begin
            state_reg  <= MAC;
            k_reg      <= k_reg + K_W'(1);
            w_addr_reg <= w_base_reg;
            w_base_reg <= w_base_reg + W_AW'(N_IN);
          end
        end
        ARGMAX: begin
          if (scan_take) begin
            max_reg <= scan_word;
            idx_reg <= 4'(j_reg);
          end
          if (j_reg == K_W'(N_OUT - 1)) begin
            inference_reg <= scan_take ? 4'(j_reg) : idx_reg;
            done_reg      <= 1'b1;
            state_reg     <= DONE;
          end else begin
            j_reg <= j_reg + K_W'(1);
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign pix_addr  = pix_addr_reg;
  assign w_addr    = w_addr_reg;
  assign inference = inference_reg;

  generate
    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_res
      assign res[gi*RES_W +: RES_W] = res_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_digit_infer_ctrl.sv
// tb_digit_infer_ctrl: scoreboard bench for digit_infer_ctrl (small N_IN=4 instance plus
// an N_IN=784 instance for saturation); expected results are queued at start, popped at done.
`timescale 1ns/1ps
module tb_digit_infer_ctrl;

  localparam int N_IN    = 4;
  localparam int N_OUT   = 10;
  localparam int BIG_IN  = 784;
  localparam int LAT     = N_OUT * (N_IN + 2) + N_OUT + 1;
  localparam int BIG_LAT = N_OUT * (BIG_IN + 2) + N_OUT + 1;

  typedef struct packed {
    logic [N_OUT*32-1:0] res;
    logic [3:0]          inf;
  } exp_t;

  logic clk = 1'b0;
  logic reset_reset_n = 1'b0;
  logic start = 1'b0;
  logic start_big = 1'b0;

  logic                busy, done;
  logic [1:0]          pix_addr;
  logic [5:0]          w_addr;
  logic [7:0]          pix_data;
  logic [15:0]         w_data;
  logic [N_OUT*32-1:0] res;
  logic [3:0]          inference;

  logic                busy_big, done_big;
  logic [9:0]          pix_addr_big;
  logic [12:0]         w_addr_big;
  logic [7:0]          pix_big = 8'd255;
  logic [15:0]         w_big = 16'h8000;
  logic [N_OUT*32-1:0] res_big;
  logic [3:0]          inference_big;

  logic [7:0]  pix_mem [N_IN];
  logic [15:0] w_mem [N_IN*N_OUT];

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  // Registered-read memories feeding the small instance.
  always @(posedge clk) begin
    pix_data <= pix_mem[pix_addr];
    w_data   <= w_mem[w_addr];
  end

  digit_infer_ctrl #(.N_IN(N_IN), .N_OUT(N_OUT), .ACC_W(40)) dut (
    .clk_clk(clk), .reset_reset_n(reset_reset_n), .start(start),
    .busy(busy), .done(done), .pix_addr(pix_addr), .w_addr(w_addr),
    .pix_data(pix_data), .w_data(w_data), .res(res), .inference(inference)
  );

  digit_infer_ctrl #(.N_IN(BIG_IN), .N_OUT(N_OUT), .ACC_W(40)) dut_big (
    .clk_clk(clk), .reset_reset_n(reset_reset_n), .start(start_big),
    .busy(busy_big), .done(done_big), .pix_addr(pix_addr_big), .w_addr(w_addr_big),
    .pix_data(pix_big), .w_data(w_big), .res(res_big), .inference(inference_big)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sat_relu(input longint v);
    logic [31:0] r;
    if (v > 64'sd2147483647) r = 32'h7fff_ffff;
    else if (v < -64'sd2147483648) r = 32'h8000_0000;
    else r = v[31:0];
`ifdef DIGIT_INFER_RELU_EN
    if (r[31]) r = '0;
`endif
    return r;
  endfunction

  function automatic exp_t model_small();
    exp_t   e;
    longint acc;
    int     best;
    e = '0;
    for (int k = 0; k < N_OUT; k++) begin
      acc = 0;
      for (int i = 0; i < N_IN; i++)
        acc += longint'($signed(w_mem[k*N_IN+i])) * longint'(pix_mem[i]);
      e.res[k*32 +: 32] = sat_relu(acc);
    end
    best = 0;
    for (int k = 1; k < N_OUT; k++)
      if ($signed(e.res[k*32 +: 32]) > $signed(e.res[best*32 +: 32])) best = k;
    e.inf = 4'(best);
    return e;
  endfunction

  task automatic load_ramp();
    for (int i = 0; i < N_IN; i++) pix_mem[i] = 8'd1;
    for (int k = 0; k < N_OUT; k++)
      for (int i = 0; i < N_IN; i++) w_mem[k*N_IN+i] = 16'(k + 1);
  endtask

  // Classes 2 and 7 tie at the top score; class 0 is negative.
  task automatic load_tie();
    for (int i = 0; i < N_IN; i++) pix_mem[i] = 8'(10 * (i + 1));
    for (int k = 0; k < N_OUT; k++)
      for (int i = 0; i < N_IN; i++)
        w_mem[k*N_IN+i] = (k == 2 || k == 7) ? 16'd100 : (k == 0) ? 16'hfffb : 16'(k);
  endtask

  task automatic load_peak(input int p);
    for (int i = 0; i < N_IN; i++) pix_mem[i] = 8'(10 * (i + 1));
    for (int k = 0; k < N_OUT; k++)
      for (int i = 0; i < N_IN; i++) w_mem[k*N_IN+i] = (k == p) ? 16'd50 : 16'd1;
  endtask

  task automatic load_random();
    for (int i = 0; i < N_IN; i++) pix_mem[i] = 8'($urandom_range(0, 255));
    for (int j = 0; j < N_IN*N_OUT; j++) w_mem[j] = 16'($urandom);
  endtask

  // start is sampled at the end of cycle 0; cycle c lies between edges c-1 and c after that.
  task automatic kick();
    @(negedge clk);
    exp_q.push_back(model_small());
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input bit poke_start,
                           input bit hold_chk, input logic [3:0] hold_val);
    int   cyc;
    bit   seen;
    exp_t e;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < LAT + 20) begin
      @(negedge clk);
      cyc++;
      if (poke_start) start = (cyc == 10 || cyc == 50 || cyc == 70);
      if (cyc == 1) check_eq({name, " busy"}, 64'(busy), 64'd1);
      if (cyc == 14) begin
        check_eq({name, " pix_addr c2 i1"}, 64'(pix_addr), 64'd1);
        check_eq({name, " w_addr c2 i1"}, 64'(w_addr), 64'd9);
      end
      if (cyc == 17) begin
        check_eq({name, " pix_addr drain"}, 64'(pix_addr), 64'd0);
        check_eq({name, " w_addr drain"}, 64'(w_addr), 64'd0);
      end
      if (hold_chk && (cyc == 1 || cyc == 35 || cyc == LAT - 1))
        check_eq({name, " inference held"}, 64'(inference), 64'(hold_val));
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check_eq({name, " done seen"}, 64'(seen), 64'd1);
    check_eq({name, " latency"}, 64'(cyc), 64'(LAT));
    if (seen && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int k = 0; k < N_OUT; k++)
        check_eq($sformatf("%s res[%0d]", name, k), 64'(res[k*32 +: 32]), 64'(e.res[k*32 +: 32]));
      check_eq({name, " inference"}, 64'(inference), 64'(e.inf));
      check_eq({name, " pix_addr idle"}, 64'(pix_addr), 64'd0);
      @(negedge clk);
      check_eq({name, " done one cycle"}, 64'(done), 64'd0);
      check_eq({name, " busy cleared"}, 64'(busy), 64'd0);
      $display("%s: inference=%0d latency=%0d", name, inference, cyc);
    end
  endtask

  task automatic run_big(input string name, input logic [15:0] w);
    int     cyc;
    bit     seen;
    exp_t   e;
    logic [31:0] s;
    w_big = w;
    s = sat_relu(longint'(BIG_IN) * 255 * longint'($signed(w)));
    for (int k = 0; k < N_OUT; k++) e.res[k*32 +: 32] = s;
    e.inf = 4'd0;
    @(negedge clk);
    exp_q.push_back(e);
    start_big = 1'b1;
    @(posedge clk);
    #1 start_big = 1'b0;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < BIG_LAT + 20) begin
      @(negedge clk);
      cyc++;
      if (done_big) seen = 1'b1;
    end
    check_eq({name, " done seen"}, 64'(seen), 64'd1);
    check_eq({name, " latency"}, 64'(cyc), 64'(BIG_LAT));
    if (seen && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq({name, " res[0]"}, 64'(res_big[31:0]), 64'(e.res[31:0]));
      check_eq({name, " res[9]"}, 64'(res_big[319:288]), 64'(e.res[319:288]));
      check_eq({name, " inference"}, 64'(inference_big), 64'(e.inf));
      $display("%s: res0=0x%08h inference=%0d latency=%0d", name, res_big[31:0], inference_big, cyc);
    end
  endtask

  initial begin
    int      extra;
    exp_t    ea;
    reset_reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset busy", 64'(busy), 64'd0);
    check_eq("reset done", 64'(done), 64'd0);
    check_eq("reset pix_addr", 64'(pix_addr), 64'd0);
    check_eq("reset w_addr", 64'(w_addr), 64'd0);
    check_eq("reset res", 64'(|res), 64'd0);
    check_eq("reset inference", 64'(inference), 64'd0);
    reset_reset_n = 1'b1;
    repeat (2) @(negedge clk);

    load_ramp();
    kick();
    wait_done("ramp", 1'b0, 1'b0, 4'd0);
    check_eq("ramp res[9] const", 64'(res[319:288]), 64'd40);
    check_eq("ramp inference const", 64'(inference), 64'd9);

    load_tie();
    ea = model_small();
    kick();
    wait_done("tie", 1'b0, 1'b0, 4'd0);
    check_eq("tie inference const", 64'(inference), 64'd2);

    load_peak(6);
    kick();
    wait_done("back2back", 1'b0, 1'b1, ea.inf);

    load_random();
    kick();
    wait_done("restart_ignored", 1'b1, 1'b0, 4'd0);
    extra = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (done) extra++;
    end
    check_eq("restart_ignored extra done", 64'(extra), 64'd0);

    load_random();
    kick();
    repeat (32) @(negedge clk);
    check_eq("abort pix_addr c5", 64'(pix_addr), 64'd1);
    check_eq("abort w_addr c5", 64'(w_addr), 64'd21);
    #1 reset_reset_n = 1'b0;
    #1;
    check_eq("abort busy", 64'(busy), 64'd0);
    check_eq("abort done", 64'(done), 64'd0);
    check_eq("abort pix_addr", 64'(pix_addr), 64'd0);
    check_eq("abort w_addr", 64'(w_addr), 64'd0);
    check_eq("abort res", 64'(|res), 64'd0);
    check_eq("abort inference", 64'(inference), 64'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset_reset_n = 1'b1;
    extra = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    check_eq("abort no done", 64'(extra), 64'd0);
    $display("abort: reset during class 5, outputs cleared");

    load_random();
    kick();
    wait_done("fresh", 1'b0, 1'b0, 4'd0);

    run_big("big_neg", 16'h8000);
    run_big("big_pos", 16'h7fff);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
